// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU package: opcode constants, memory-port arbiter state encoding and fairness default.
package mem_port_arbiter_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int FAIR_LIMIT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Starvation counter for the memory-port arbiter: counts data grants made while fetch waits.
module arb_starve_cnt #(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Saturates at LIMIT; a fetch grant always follows, which clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CW'(1);
        end
    end

    assign at_limit = (count == CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one synchronous single-port memory.
// Define ARB_FAIR_EN to bound how long fetch can be starved by back-to-back data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FAIR_LIMIT = FAIR_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t state, state_next;
    logic       fair_force;
    logic       grant_dm;
    logic       grant_if;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

`ifdef ARB_FAIR_EN
    logic at_limit;

    arb_starve_cnt #(
        .LIMIT (FAIR_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      ((state == IDLE) && grant_dm && if_req),
        .clr      ((state == IDLE) && grant_if),
        .at_limit (at_limit)
    );

    assign fair_force = at_limit & if_req;
`else
    assign fair_force = 1'b0;
`endif

    assign grant_dm = dm_req & ~fair_force;
    assign grant_if = if_req & (~dm_req | fair_force);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Access states always fall back to IDLE, so a dropped request cannot wedge the FSM.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_dm) begin
                    state_next = DM_ACC;
                end else if (grant_if) begin
                    state_next = IF_ACC;
                end
            end
            IF_ACC:  state_next = IDLE;
            DM_ACC:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        dm_ack    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        mem_en    = 1'b1;
                        mem_we    = dm_we;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                    end else if (grant_if) begin
                        mem_en   = 1'b1;
                        mem_addr = if_addr;
                    end
                end
                IF_ACC:  if_ack = 1'b1;
                DM_ACC:  dm_ack = 1'b1;
                default: ;
            endcase
        end
    end

    // Keep the last delivered word visible after the ack pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (if_ack) if_rdata_q <= mem_rdata;
            if (dm_ack) dm_rdata_q <= mem_rdata;
        end
    end

    assign if_rdata  = rst ? '0 : (if_ack ? mem_rdata : if_rdata_q);
    assign dm_rdata  = rst ? '0 : (dm_ack ? mem_rdata : dm_rdata_q);
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small synchronous memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FAIR_LIMIT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    // Single-port memory: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16]   = 32'h2002_0005;
        mem[17]   = 32'h3333_4444;
        mem[64]   = 32'h1111_2222;
        mem_rdata = 32'h0;
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;

        tick(); tick();
        check("rst_if_ack",   {31'b0, if_ack}, 32'd0);
        check("rst_dm_ack",   {31'b0, dm_ack}, 32'd0);
        check("rst_mem_en",   {31'b0, mem_en}, 32'd0);
        check("rst_mem_we",   {31'b0, mem_we}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Fetch only
        if_req = 1'b1; if_addr = 32'h0000_0040;
        #1;
        check("if_c0_mem_en",   {31'b0, mem_en},   32'd1);
        check("if_c0_mem_we",   {31'b0, mem_we},   32'd0);
        check("if_c0_mem_addr", mem_addr,          32'h40);
        check("if_c0_stall_if", {31'b0, stall_if}, 32'd1);
        check("if_c0_if_ack",   {31'b0, if_ack},   32'd0);
        tick();
        check("if_c1_if_ack",   {31'b0, if_ack},   32'd1);
        check("if_c1_if_rdata", if_rdata,          32'h2002_0005);
        check("if_c1_stall_if", {31'b0, stall_if}, 32'd0);
        check("if_c1_mem_en",   {31'b0, mem_en},   32'd0);
        if_req = 1'b0;
        tick();
        check("if_c2_if_ack",  {31'b0, if_ack}, 32'd0);
        check("if_c2_held",    if_rdata,        32'h2002_0005);

        // Load vs fetch collision
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h44;
        #1;
        check("col_c0_mem_addr", mem_addr,         32'h100);
        check("col_c0_mem_en",   {31'b0, mem_en},  32'd1);
        tick();
        check("col_c1_dm_ack",   {31'b0, dm_ack},   32'd1);
        check("col_c1_dm_rdata", dm_rdata,          32'h1111_2222);
        check("col_c1_if_ack",   {31'b0, if_ack},   32'd0);
        check("col_c1_stall_if", {31'b0, stall_if}, 32'd1);
        check("col_c1_stall_mem",{31'b0, stall_mem},32'd0);
        check("col_c1_mem_en",   {31'b0, mem_en},   32'd0);
        dm_req = 1'b0;
        tick();
        check("col_c2_mem_en",   {31'b0, mem_en}, 32'd1);
        check("col_c2_mem_addr", mem_addr,        32'h44);
        tick();
        check("col_c3_if_ack",   {31'b0, if_ack}, 32'd1);
        check("col_c3_if_rdata", if_rdata,        32'h3333_4444);
        if_req = 1'b0;
        tick();

        // Store, then load it back
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h104; dm_wdata = 32'hDEAD_BEEF;
        #1;
        check("st_c0_mem_en",    {31'b0, mem_en}, 32'd1);
        check("st_c0_mem_we",    {31'b0, mem_we}, 32'd1);
        check("st_c0_mem_addr",  mem_addr,        32'h104);
        check("st_c0_mem_wdata", mem_wdata,       32'hDEAD_BEEF);
        check("st_c0_dm_ack",    {31'b0, dm_ack}, 32'd0);
        tick();
        check("st_c1_mem_we",    {31'b0, mem_we}, 32'd0);
        check("st_c1_dm_ack",    {31'b0, dm_ack}, 32'd1);
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        dm_req = 1'b1; dm_addr = 32'h104;
        tick();
        check("ld_back_dm_ack",   {31'b0, dm_ack}, 32'd1);
        check("ld_back_dm_rdata", dm_rdata,        32'hDEAD_BEEF);
        dm_req = 1'b0;
        tick();

        // Both requests held continuously: grant order
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h44;
        for (int g = 0; g < 8; g++) begin
            logic [31:0] exp_addr;
`ifdef ARB_FAIR_EN
            exp_addr = ((g % 4) == 3) ? 32'h44 : 32'h100;
`else
            exp_addr = 32'h100;
`endif
            #1;
            check($sformatf("fair_grant%0d_addr", g), mem_addr, exp_addr);
            check($sformatf("fair_grant%0d_en", g), {31'b0, mem_en}, 32'd1);
            tick();
            tick();
        end
        dm_req = 1'b0; if_req = 1'b0;
        tick(); tick();

        // Reset in the middle of a data access
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        #1;
        check("rm_c0_mem_en", {31'b0, mem_en}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("rm_rst_dm_ack",   {31'b0, dm_ack}, 32'd0);
        check("rm_rst_mem_en",   {31'b0, mem_en}, 32'd0);
        check("rm_rst_mem_we",   {31'b0, mem_we}, 32'd0);
        check("rm_rst_dm_rdata", dm_rdata,        32'h0);
        check("rm_rst_if_ack",   {31'b0, if_ack}, 32'd0);
        tick();
        check("rm_rst2_dm_ack",  {31'b0, dm_ack}, 32'd0);
        check("rm_rst2_mem_en",  {31'b0, mem_en}, 32'd0);
        rst = 1'b0;
        #1;
        check("rm_regrant_en",   {31'b0, mem_en}, 32'd1);
        check("rm_regrant_addr", mem_addr,        32'h100);
        tick();
        check("rm_ack",          {31'b0, dm_ack}, 32'd1);
        check("rm_rdata",        dm_rdata,        32'h1111_2222);
        dm_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, memory address width in bits.
REQ-002 SHALL have parameter DATA_W, 32, memory data width in bits.
REQ-003 SHALL have parameter FAIR_LIMIT, 3, maximum consecutive data grants while fetch waits; used only with ARB_FAIR_EN.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port if_req  in  1  instruction-fetch read request, held until if_ack.
REQ-007 SHALL have port if_addr  in  ADDR_W  fetch address.
REQ-008 SHALL have port if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid.
REQ-009 SHALL have port if_rdata  out  DATA_W  fetched word.
REQ-010 SHALL have port dm_req  in  1  data-memory request, held until dm_ack.
REQ-011 SHALL have port dm_we  in  1  1 = store, 0 = load.
REQ-012 SHALL have port dm_addr  in  ADDR_W  data address.
REQ-013 SHALL have port dm_wdata  in  DATA_W  store data.
REQ-014 SHALL have port dm_ack  out  1  one-cycle pulse: data access done, dm_rdata valid for loads.
REQ-015 SHALL have port dm_rdata  out  DATA_W  load data.
REQ-016 SHALL have ports mem_en / mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), mem_rdata (in, DATA_W): single-port synchronous memory, read data one cycle after mem_en.
REQ-017 SHALL have ports stall_if  out  1  and stall_mem  out  1: pipeline freeze requests.

Function
REQ-018 SHALL implement FSM states IDLE, IF_ACC and DM_ACC.
REQ-019 In IDLE with dm_req=1, SHALL drive mem_en=1, mem_we=dm_we, mem_addr=dm_addr, mem_wdata=dm_wdata, and enter DM_ACC.
REQ-020 In IDLE with only if_req=1, SHALL drive mem_en=1, mem_we=0, mem_addr=if_addr, and enter IF_ACC.
REQ-021 On simultaneous requests, data SHALL win, except as overridden by REQ-031.
REQ-022 In IF_ACC, SHALL pulse if_ack with if_rdata=mem_rdata, then return to IDLE.
REQ-023 In DM_ACC, SHALL pulse dm_ack with dm_rdata=mem_rdata (loads; value don't-care for stores), then return to IDLE.
REQ-024 Latency: each access SHALL complete two cycles after the request is seen in IDLE; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-025 mem_en SHALL be asserted only in IDLE grant cycles and never in IF_ACC or DM_ACC.
REQ-026 stall_if SHALL equal if_req & ~if_ack, and stall_mem SHALL equal dm_req & ~dm_ack, both combinational.
REQ-027 Request deassertion before ack is illegal; behaviour for it is unspecified, and the block SHALL NOT hang on it.

Reset
REQ-028 While rst=1, the FSM SHALL go to IDLE, and if_ack, dm_ack, mem_en, mem_we and the starvation counter SHALL be 0; rdata registers SHALL be 0.
REQ-029 Reset during IF_ACC or DM_ACC SHALL abandon the access with no ack; arbitration resumes in the first cycle after rst falls.

Configuration
REQ-030 Macro ARB_FAIR_EN SHALL select fairness logic.
REQ-031 With ARB_FAIR_EN defined, a counter SHALL increment on each data grant made while if_req=1 and clear on any fetch grant; when the counter reaches FAIR_LIMIT, the next IDLE with if_req=1 SHALL grant fetch regardless of dm_req.
REQ-032 Without ARB_FAIR_EN, there SHALL be strict data priority and no counter hardware.

Structure
REQ-033 FSM state encodings and the FAIR_LIMIT default SHALL live in the shared CPU header/package next to the opcode constants.
REQ-034 The starvation counter SHALL be a sub-module arb_starve_cnt, instantiated only under ARB_FAIR_EN.

Verification
REQ-035 Fetch only: if_req=1, if_addr=0x0000_0040, mem returns 0x2002_0005 -> mem_en in cycle 0, if_ack in cycle 1, if_rdata=0x2002_0005, stall_if=1 in cycle 0 only.
REQ-036 Load vs fetch collision: dm_req=1, dm_we=0, dm_addr=0x100, and if_req=1 together -> DM granted first, dm_ack in cycle 1, IDLE in cycle 2, fetch granted in cycle 2, if_ack in cycle 3.
REQ-037 Store: dm_we=1, dm_addr=0x104, dm_wdata=0xDEAD_BEEF -> mem_we=1 with matching address and data for exactly one cycle; dm_ack one cycle later.
REQ-038 Fairness (ARB_FAIR_EN, FAIR_LIMIT=3): dm_req and if_req held high continuously -> grant order D, D, D, I, D, D, D, I; without the macro, fetch is never granted.
REQ-039 Reset mid-access: assert rst during DM_ACC -> no dm_ack, all outputs 0; after rst falls with dm_req still high, the access is re-granted and acked.
